alu_result_stage: RTL and testbench

Registered execute-to-writeback stage directly downstream of the ALU. Captures each valid ALU result with its ROB tag into a small FIFO and presents it to the common writeback bus under a valid/ready handshake. Resolves conditional branches at capture: compares the ALU branch condition against the front-end prediction and emits a one-cycle redirect on mispredict. Absorbs writeback-bus back-pressure so the ALU never stalls mid-operation.

---
 rtl/alu_result_stage_pkg.sv | 22 ++
 rtl/alu_result_stage_if.sv | 41 ++++
 rtl/alu_result_stage_sync_fifo.sv | 59 +++++
 rtl/alu_result_stage.sv | 75 +++++++
 tb/tb_alu_result_stage.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared types for the ALU result stage: opcodes, the writeback entry layout
// and the branch classifier.
package alu_result_stage_pkg;

  localparam int unsigned DEF_ROB_IDX_W = 5;

  typedef enum logic [4:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra, OpSlt, OpSltu, OpLui,
    OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu
  } instr_opcode;

  typedef struct packed {
    logic [DEF_ROB_IDX_W-1:0] rob_idx;
    logic [31:0]              value;
    logic                     rd_en;
  } alu_wb_entry_t;

  function automatic logic is_branch(instr_opcode op);
    return op inside {OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu};
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// ALU-side input, writeback-bus output and redirect signals of the result stage.
// master = surrounding pipeline, slave = the stage itself.
interface alu_result_stage_if #(
  parameter int unsigned ROB_IDX_W = alu_result_stage_pkg::DEF_ROB_IDX_W
);
  import alu_result_stage_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  instr_opcode          in_opcode;
  logic [31:0]          in_result;
  logic                 in_br_cond;
  logic [31:0]          in_pc;
  logic [31:0]          in_imm;
  logic                 in_pred_taken;
  logic [ROB_IDX_W-1:0] in_rob_idx;
  logic                 flush;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [ROB_IDX_W-1:0] wb_rob_idx;
  logic [31:0]          wb_value;
  logic                 wb_rd_en;
  logic                 redirect_valid;
  logic [31:0]          redirect_pc;
  logic [ROB_IDX_W-1:0] redirect_rob_idx;

  modport master (
    output in_valid, in_opcode, in_result, in_br_cond, in_pc, in_imm, in_pred_taken,
           in_rob_idx, flush, wb_ready,
    input  in_ready, wb_valid, wb_rob_idx, wb_value, wb_rd_en, redirect_valid,
           redirect_pc, redirect_rob_idx
  );

  modport slave (
    input  in_valid, in_opcode, in_result, in_br_cond, in_pc, in_imm, in_pred_taken,
           in_rob_idx, flush, wb_ready,
    output in_ready, wb_valid, wb_rob_idx, wb_value, wb_rd_en, redirect_valid,
           redirect_pc, redirect_rob_idx
  );

endinterface

// File: rtl/alu_result_stage_sync_fifo.sv
// Count-based synchronous FIFO with registered storage and a flush that
// drops every entry; push/pop requests are masked internally by full/empty.
module alu_result_stage_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_head];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= i_data;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: queues ALU results for the writeback bus and
// resolves conditional branches at capture, pulsing a redirect on mispredict.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int unsigned ROB_IDX_W = DEF_ROB_IDX_W,
  parameter int unsigned DEPTH     = 2
) (
  input logic               clk,
  input logic               rst,
  alu_result_stage_if.slave bus
);

  localparam int unsigned ENT_W = ROB_IDX_W + 33;

  logic                 w_is_br;
  logic                 w_enq;
  logic                 w_deq;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_mispredict;
  logic [31:0]          w_target;
  logic [ENT_W-1:0]     w_entry;
  logic [ENT_W-1:0]     w_head;
  logic                 r_redirect_valid;
  logic [31:0]          r_redirect_pc;
  logic [ROB_IDX_W-1:0] r_redirect_rob_idx;

  assign w_is_br      = is_branch(bus.in_opcode);
  assign w_enq        = bus.in_valid && !w_full && !bus.flush;
  assign w_deq        = !w_empty && bus.wb_ready;
  assign w_target     = bus.in_br_cond ? (bus.in_pc + bus.in_imm) : (bus.in_pc + 32'd4);
  assign w_mispredict = w_enq && w_is_br && (bus.in_br_cond != bus.in_pred_taken);
  // Layout matches alu_wb_entry_t: {rob_idx, value, rd_en}.
  assign w_entry      = {bus.in_rob_idx, (w_is_br ? 32'h0 : bus.in_result), !w_is_br};

  alu_result_stage_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (bus.flush),
    .i_push  (w_enq),
    .i_pop   (w_deq),
    .i_data  (w_entry),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect_valid   <= 1'b0;
      r_redirect_pc      <= '0;
      r_redirect_rob_idx <= '0;
    end else begin
      r_redirect_valid <= w_mispredict;
      if (w_mispredict) begin
        r_redirect_pc      <= w_target;
        r_redirect_rob_idx <= bus.in_rob_idx;
      end
    end
  end

  assign bus.in_ready         = !w_full;
  assign bus.wb_valid         = !w_empty;
  assign bus.wb_rob_idx       = w_head[ENT_W-1 -: ROB_IDX_W];
  assign bus.wb_value         = w_head[32:1];
  assign bus.wb_rd_en         = w_head[0];
  assign bus.redirect_valid   = r_redirect_valid;
  assign bus.redirect_pc      = r_redirect_pc;
  assign bus.redirect_rob_idx = r_redirect_rob_idx;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_alu_result_stage;
  import alu_result_stage_pkg::*;

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned NUM_OPS = 17;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_result_stage_if #(.ROB_IDX_W(5)) bus_if ();

  alu_result_stage #(
    .ROB_IDX_W (5),
    .DEPTH     (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus_if.in_valid      = 1'b0;
    bus_if.in_opcode     = OpAdd;
    bus_if.in_result     = '0;
    bus_if.in_br_cond    = 1'b0;
    bus_if.in_pc         = '0;
    bus_if.in_imm        = '0;
    bus_if.in_pred_taken = 1'b0;
    bus_if.in_rob_idx    = '0;
    bus_if.flush         = 1'b0;
  endtask

  task automatic drive_op(input instr_opcode op, input logic [31:0] res, input logic [4:0] tag,
                          input logic [31:0] pc, input logic [31:0] imm, input logic cond,
                          input logic pred);
    bus_if.in_valid      = 1'b1;
    bus_if.in_opcode     = op;
    bus_if.in_result     = res;
    bus_if.in_rob_idx    = tag;
    bus_if.in_pc         = pc;
    bus_if.in_imm        = imm;
    bus_if.in_br_cond    = cond;
    bus_if.in_pred_taken = pred;
  endtask

  task automatic clear_queue();
    drive_idle();
    bus_if.flush = 1'b1;
    tick();
    bus_if.flush = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    bus_if.wb_ready = 1'b0;
    #12;
    checks++; if (bus_if.wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid: got %b want 0", bus_if.wb_valid); end
    checks++; if (bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", bus_if.in_ready); end
    checks++; if (bus_if.redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_redirect_valid: got %b want 0", bus_if.redirect_valid); end
    checks++; if (bus_if.redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_redirect_pc: got %h want 0", bus_if.redirect_pc); end
    checks++; if ({bus_if.wb_rob_idx, bus_if.wb_value, bus_if.wb_rd_en} !== 38'h0) begin failures++; $display("FAIL reset_wb_data: got %h/%h/%b want 0", bus_if.wb_rob_idx, bus_if.wb_value, bus_if.wb_rd_en); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_add();
    bus_if.wb_ready = 1'b1;
    drive_op(OpAdd, 32'h0000_0005, 5'd3, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    drive_idle();
    checks++; if (bus_if.wb_valid !== 1'b1) begin failures++; $display("FAIL add_wb_valid: got %b want 1", bus_if.wb_valid); end
    checks++; if (bus_if.wb_value !== 32'h5) begin failures++; $display("FAIL add_value: got %h want 5", bus_if.wb_value); end
    checks++; if (bus_if.wb_rob_idx !== 5'd3) begin failures++; $display("FAIL add_tag: got %0d want 3", bus_if.wb_rob_idx); end
    checks++; if (bus_if.wb_rd_en !== 1'b1) begin failures++; $display("FAIL add_rd_en: got %b want 1", bus_if.wb_rd_en); end
    checks++; if (bus_if.redirect_valid !== 1'b0) begin failures++; $display("FAIL add_no_redirect: got %b want 0", bus_if.redirect_valid); end
    tick();
    checks++; if (bus_if.wb_valid !== 1'b0) begin failures++; $display("FAIL add_drained: got %b want 0", bus_if.wb_valid); end
  endtask

  task automatic test_backpressure();
    bus_if.wb_ready = 1'b0;
    drive_op(OpSub, 32'h11, 5'd1, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++; if (bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after_one: got %b want 1", bus_if.in_ready); end
    drive_op(OpXor, 32'h22, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++; if (bus_if.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready: got %b want 0", bus_if.in_ready); end
    drive_op(OpOr, 32'h33, 5'd9, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++; if (bus_if.wb_rob_idx !== 5'd1 || bus_if.wb_value !== 32'h11) begin failures++; $display("FAIL bp_head_stable: got %0d/%h want 1/11", bus_if.wb_rob_idx, bus_if.wb_value); end
    checks++; if (bus_if.in_ready !== 1'b0) begin failures++; $display("FAIL bp_still_full: got %b want 0", bus_if.in_ready); end
    drive_idle();
    bus_if.wb_ready = 1'b1;
    tick();
    checks++; if (bus_if.wb_rob_idx !== 5'd2 || bus_if.wb_value !== 32'h22) begin failures++; $display("FAIL bp_second: got %0d/%h want 2/22", bus_if.wb_rob_idx, bus_if.wb_value); end
    checks++; if (bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after_pop: got %b want 1", bus_if.in_ready); end
    tick();
    checks++; if (bus_if.wb_valid !== 1'b0) begin failures++; $display("FAIL bp_third_ignored: got %b want 0", bus_if.wb_valid); end
  endtask

  task automatic test_branch();
    bus_if.wb_ready = 1'b1;
    drive_op(OpBeq, 32'hDEAD_BEEF, 5'd7, 32'h100, 32'h20, 1'b1, 1'b0);
    tick();
    drive_idle();
    checks++; if (bus_if.redirect_valid !== 1'b1) begin failures++; $display("FAIL beq_redirect: got %b want 1", bus_if.redirect_valid); end
    checks++; if (bus_if.redirect_pc !== 32'h120) begin failures++; $display("FAIL beq_pc: got %h want 120", bus_if.redirect_pc); end
    checks++; if (bus_if.redirect_rob_idx !== 5'd7) begin failures++; $display("FAIL beq_tag: got %0d want 7", bus_if.redirect_rob_idx); end
    checks++; if (bus_if.wb_valid !== 1'b1 || bus_if.wb_rd_en !== 1'b0 || bus_if.wb_value !== 32'h0) begin failures++; $display("FAIL beq_wb: got %b/%b/%h want 1/0/0", bus_if.wb_valid, bus_if.wb_rd_en, bus_if.wb_value); end
    tick();
    checks++; if (bus_if.redirect_valid !== 1'b0) begin failures++; $display("FAIL beq_one_cycle: got %b want 0", bus_if.redirect_valid); end
    drive_op(OpBne, 32'h0, 5'd12, 32'hFFFF_FFFC, 32'h40, 1'b0, 1'b1);
    tick();
    drive_idle();
    checks++; if (bus_if.redirect_valid !== 1'b1 || bus_if.redirect_pc !== 32'h0) begin failures++; $display("FAIL bne_wrap: got %b/%h want 1/0", bus_if.redirect_valid, bus_if.redirect_pc); end
    drive_op(OpBlt, 32'h0, 5'd13, 32'h200, 32'h8, 1'b1, 1'b1);
    tick();
    drive_idle();
    checks++; if (bus_if.redirect_valid !== 1'b0) begin failures++; $display("FAIL blt_correct_pred: got %b want 0", bus_if.redirect_valid); end
    checks++; if (bus_if.wb_valid !== 1'b1 || bus_if.wb_rob_idx !== 5'd13) begin failures++; $display("FAIL blt_enqueued: got %b/%0d want 1/13", bus_if.wb_valid, bus_if.wb_rob_idx); end
    tick();
  endtask

  task automatic test_flush();
    bus_if.wb_ready = 1'b0;
    drive_op(OpAdd, 32'h1, 5'd1, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    drive_op(OpAdd, 32'h2, 5'd2, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    drive_op(OpBge, 32'h0, 5'd4, 32'h300, 32'h10, 1'b1, 1'b0);
    bus_if.flush = 1'b1;
    tick();
    drive_idle();
    checks++; if (bus_if.wb_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL flush_full: got valid %b ready %b want 0/1", bus_if.wb_valid, bus_if.in_ready); end
    checks++; if (bus_if.redirect_valid !== 1'b0) begin failures++; $display("FAIL flush_full_redirect: got %b want 0", bus_if.redirect_valid); end
    // One entry leaves room, so the branch would be accepted without the flush.
    drive_op(OpAdd, 32'h5, 5'd5, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    drive_op(OpBltu, 32'h0, 5'd6, 32'h400, 32'h10, 1'b0, 1'b1);
    bus_if.flush = 1'b1;
    tick();
    drive_idle();
    checks++; if (bus_if.wb_valid !== 1'b0 || bus_if.redirect_valid !== 1'b0) begin failures++; $display("FAIL flush_suppress: got valid %b redirect %b want 0/0", bus_if.wb_valid, bus_if.redirect_valid); end
  endtask

  task automatic test_random();
    alu_wb_entry_t q[$];
    alu_wb_entry_t e;
    logic          exp_rv;
    logic [31:0]   exp_rpc;
    logic [4:0]    exp_rtag;
    logic [4:0]    op_v;
    logic          br;
    logic          accept;
    instr_opcode   op;
    clear_queue();
    exp_rv = 1'b0;
    exp_rpc = '0;
    exp_rtag = '0;
    for (int i = 0; i < 600; i++) begin
      checks++; if (bus_if.wb_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_wb_valid@%0d: got %b want %b", i, bus_if.wb_valid, q.size() != 0); end
      checks++; if (bus_if.in_ready !== (q.size() < DEPTH)) begin failures++; $display("FAIL rnd_in_ready@%0d: got %b want %b", i, bus_if.in_ready, q.size() < DEPTH); end
      if (q.size() != 0) begin
        checks++; if ({bus_if.wb_rob_idx, bus_if.wb_value, bus_if.wb_rd_en} !== q[0]) begin failures++; $display("FAIL rnd_head@%0d: got %h/%h/%b want %h/%h/%b", i, bus_if.wb_rob_idx, bus_if.wb_value, bus_if.wb_rd_en, q[0].rob_idx, q[0].value, q[0].rd_en); end
      end
      checks++; if (bus_if.redirect_valid !== exp_rv) begin failures++; $display("FAIL rnd_redirect@%0d: got %b want %b", i, bus_if.redirect_valid, exp_rv); end
      if (exp_rv) begin
        checks++; if (bus_if.redirect_pc !== exp_rpc || bus_if.redirect_rob_idx !== exp_rtag) begin failures++; $display("FAIL rnd_redirect_data@%0d: got %h/%0d want %h/%0d", i, bus_if.redirect_pc, bus_if.redirect_rob_idx, exp_rpc, exp_rtag); end
      end
      op_v = 5'($urandom_range(0, NUM_OPS - 1));
      op   = instr_opcode'(op_v);
      drive_op(op, $urandom, 5'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      bus_if.in_valid = ($urandom_range(0, 3) != 0);
      bus_if.flush    = ($urandom_range(0, 24) == 0);
      bus_if.wb_ready = ($urandom_range(0, 2) != 0);
      br     = op inside {OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu};
      accept = bus_if.in_valid && (q.size() < DEPTH) && !bus_if.flush;
      if (bus_if.flush) begin
        q.delete();
        exp_rv = 1'b0;
      end else begin
        if (q.size() != 0 && bus_if.wb_ready) void'(q.pop_front());
        if (accept) begin
          e.rob_idx = bus_if.in_rob_idx;
          e.value   = br ? 32'h0 : bus_if.in_result;
          e.rd_en   = !br;
          q.push_back(e);
        end
        exp_rv = accept && br && (bus_if.in_br_cond != bus_if.in_pred_taken);
        if (exp_rv) begin
          exp_rpc  = bus_if.in_br_cond ? bus_if.in_pc + bus_if.in_imm : bus_if.in_pc + 32'd4;
          exp_rtag = bus_if.in_rob_idx;
        end
      end
      tick();
    end
    drive_idle();
  endtask

  task automatic test_async_reset();
    clear_queue();
    bus_if.wb_ready = 1'b0;
    drive_op(OpAnd, 32'hAA, 5'd1, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    drive_op(OpBeq, 32'h0, 5'd2, 32'h500, 32'h40, 1'b1, 1'b0);
    tick();
    drive_idle();
    checks++; if (bus_if.in_ready !== 1'b0 || bus_if.redirect_valid !== 1'b1) begin failures++; $display("FAIL ar_setup: got ready %b redirect %b want 0/1", bus_if.in_ready, bus_if.redirect_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus_if.wb_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin failures++; $display("FAIL ar_queue: got valid %b ready %b want 0/1", bus_if.wb_valid, bus_if.in_ready); end
    checks++; if (bus_if.redirect_valid !== 1'b0 || bus_if.redirect_pc !== 32'h0 || bus_if.redirect_rob_idx !== 5'd0) begin failures++; $display("FAIL ar_redirect: got %b/%h/%0d want 0/0/0", bus_if.redirect_valid, bus_if.redirect_pc, bus_if.redirect_rob_idx); end
    checks++; if ({bus_if.wb_rob_idx, bus_if.wb_value, bus_if.wb_rd_en} !== 38'h0) begin failures++; $display("FAIL ar_wb_data: got %h/%h/%b want 0", bus_if.wb_rob_idx, bus_if.wb_value, bus_if.wb_rd_en); end
    tick();
    #2 rst = 1'b0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    test_reset();
    test_single_add();
    test_backpressure();
    test_branch();
    test_flush();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
